mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, number of ACCESS-state cycles without mem_ack before the access is abandoned (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  ALU-side operation valid this cycle.
REQ-005 in_ready  output  1  stage can accept an operation this cycle.
REQ-006 opcode  input  6  instruction opcode accompanying the ALU result.
REQ-007 alu_result  input  32  ALU result; effective address for lw/sw.
REQ-008 alu_rw  input  1  ALU register-write flag (1 = result targets a register).
REQ-009 store_data  input  32  rt value written by sw.
REQ-010 dest_reg  input  5  destination register index.
REQ-011 mem_req  output  1  data-memory request, held until mem_ack or timeout.
REQ-012 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-013 mem_addr  output  32  registered word address; valid while mem_req=1.
REQ-014 mem_wdata  output  32  registered store data; valid while mem_req=1 and mem_we=1.
REQ-015 mem_ack  input  1  memory completion, single-cycle pulse.
REQ-016 mem_rdata  input  32  load data, valid in the mem_ack cycle.
REQ-017 wb_valid  output  1  one-cycle register write-back strobe.
REQ-018 wb_reg  output  5  write-back register index, valid with wb_valid.
REQ-019 wb_data  output  32  write-back data, valid with wb_valid.
REQ-020 err_misalign  output  1  one-cycle pulse: lw/sw address[1:0] != 0.
REQ-021 err_timeout  output  1  one-cycle pulse: access abandoned after TIMEOUT_CYC cycles.

Function
REQ-022 FSM states IDLE, ACCESS, WB; in_ready = 1 only in IDLE; accept = in_valid & in_ready.
REQ-023 Accept, opcode 000000 with alu_rw=1: latch dest_reg/alu_result, go WB; wb_valid in the cycle after accept (latency 1).
REQ-024 Accept, opcode 100011 (lw), alu_result[1:0]=00: latch address, go ACCESS with mem_we=0.
REQ-025 Accept, opcode 101011 (sw), alu_result[1:0]=00: latch address and store_data, go ACCESS with mem_we=1.
REQ-026 Accept, lw/sw with alu_result[1:0]!=00: no memory request, err_misalign=1 in next cycle, stay IDLE.
REQ-027 Accept of any other opcode (incl. 000100 beq, or 000000 with alu_rw=0): consumed, no memory or write-back activity, stay IDLE.
REQ-028 ACCESS: mem_req=1 every cycle; mem_addr/mem_we/mem_wdata stable until exit.
REQ-029 ACCESS, mem_ack=1, read: capture mem_rdata into wb_data, go WB; wb_valid in the cycle after mem_ack.
REQ-030 ACCESS, mem_ack=1, write: go IDLE; no wb_valid.
REQ-031 8-bit wait counter cleared on ACCESS entry, increments each ACCESS cycle without mem_ack; when it reaches TIMEOUT_CYC: mem_req deasserts next cycle, err_timeout pulses one cycle, go IDLE, no write-back.
REQ-032 mem_ack in the same cycle the counter reaches TIMEOUT_CYC: ack wins, normal completion, no err_timeout.
REQ-033 mem_ack outside ACCESS is ignored.
REQ-034 WB lasts exactly one cycle then returns IDLE; in_ready=0 during WB.
REQ-035 dest_reg=0: wb_valid suppressed (register $0), memory access of a lw still performed, FSM timing unchanged.
REQ-036 Sustained throughput: one R-type every 2 cycles; inputs ignored while in_ready=0.

Reset
REQ-037 rst_n=0 forces immediately (asynchronously): state IDLE, in_ready=1 after release, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_reg=0, wb_data=0, err_misalign=0, err_timeout=0, wait counter=0.
REQ-038 Reset asserted mid-ACCESS or mid-WB abandons the operation; no write-back or error pulse after release.
REQ-039 First accept possible in the first rising edge with rst_n=1.

Verification
REQ-040 R-type: opcode=000000, alu_rw=1, dest_reg=5, alu_result=0x0000_00AB -> next cycle wb_valid=1, wb_reg=5, wb_data=0x0000_00AB, then IDLE.
REQ-041 lw addr 0x100, dest_reg=8, mem_ack after 3 cycles with mem_rdata=0xDEAD_BEEF -> mem_req=1/mem_we=0/mem_addr=0x100 for 3 cycles, then wb_valid=1, wb_reg=8, wb_data=0xDEAD_BEEF.
REQ-042 sw addr 0x204, store_data=0x1234_5678, ack after 1 cycle -> mem_we=1, mem_wdata=0x1234_5678, no wb_valid, in_ready=1 the cycle after ack.
REQ-043 lw addr 0x102 -> no mem_req, err_misalign pulse 1 cycle; beq opcode 000100 -> no activity at all.
REQ-044 lw with no mem_ack, TIMEOUT_CYC=16 -> mem_req high 16 cycles, err_timeout pulse, no wb_valid; repeat with ack on cycle 16 -> normal completion, no err_timeout.
REQ-045 rst_n low during ACCESS cycle 2 -> mem_req=0 immediately, all outputs at reset values, no wb_valid after release.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: R-type write-back, lw/sw data-memory access with
// misalignment detection and a bounded wait for the memory acknowledge.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] alu_result,
  input  logic        alu_rw,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_reg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        err_misalign,
  output logic        err_timeout
);

  localparam logic [5:0] OP_R  = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [7:0] LAST  = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WB
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdat_q, wdat_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;
  logic [7:0]  cnt_q, cnt_d;

  logic is_r, is_mem, aligned;

  assign is_r    = (opcode == OP_R) && alu_rw;
  assign is_mem  = (opcode == OP_LW) || (opcode == OP_SW);
  assign aligned = (alu_result[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wreg_d  = wreg_q;
    wdat_d  = wdat_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          unique case (1'b1)
            is_r: begin
              wreg_d  = dest_reg;
              wdat_d  = alu_result;
              state_d = WB;
            end
            is_mem && aligned: begin
              addr_d  = alu_result;
              we_d    = (opcode == OP_SW);
              wreg_d  = dest_reg;
              cnt_d   = 8'd0;
              state_d = ACCESS;
              if (opcode == OP_SW)
                wdata_d = store_data;
            end
            is_mem && !aligned: mis_d = 1'b1;
            default: ;
          endcase
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          if (we_q) begin
            state_d = IDLE;
          end else begin
            wdat_d  = mem_rdata;
            state_d = WB;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          // Counter hits TIMEOUT_CYC at this edge: give up.
          if (cnt_q == LAST) begin
            to_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wreg_q  <= 5'd0;
      wdat_q  <= 32'd0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wreg_q  <= wreg_d;
      wdat_q  <= wdat_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign mem_req      = (state_q == ACCESS);
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign wb_valid     = (state_q == WB) && (wreg_q != 5'd0);
  assign wb_reg       = wreg_q;
  assign wb_data      = wdat_q;
  assign err_misalign = mis_q;
  assign err_timeout  = to_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage, checked against a per-transaction
// model of the stage's visible behaviour.
module tb_mem_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [31:0] alu_result;
  logic        alu_rw;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        err_misalign;
  logic        err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .alu_result   (alu_result),
    .alu_rw       (alu_rw),
    .store_data   (store_data),
    .dest_reg     (dest_reg),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk(input logic en);
    in_valid   = en & $urandom_range(0, 1);
    opcode     = 6'($urandom);
    alu_result = $urandom;
    alu_rw     = 1'($urandom);
    store_data = $urandom;
    dest_reg   = 5'($urandom);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".rdy"}, 32'(in_ready), 1);
    chk({tag, ".req"}, 32'(mem_req), 0);
    chk({tag, ".wbv"}, 32'(wb_valid), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".req"}, 32'(mem_req), 0);
    chk({tag, ".we"},  32'(mem_we), 0);
    chk({tag, ".adr"}, mem_addr, 0);
    chk({tag, ".wd"},  mem_wdata, 0);
    chk({tag, ".wbv"}, 32'(wb_valid), 0);
    chk({tag, ".wbr"}, 32'(wb_reg), 0);
    chk({tag, ".wbd"}, wb_data, 0);
    chk({tag, ".mis"}, 32'(err_misalign), 0);
    chk({tag, ".to"},  32'(err_timeout), 0);
  endtask

  // One transaction; ack_dly = ACCESS cycle (1-based) carrying mem_ack.
  task automatic run_op(input logic [5:0]  op,
                        input logic        rw,
                        input logic [4:0]  dst,
                        input logic [31:0] res,
                        input logic [31:0] sd,
                        input int          ack_dly,
                        input logic [31:0] rd);
    bit r_type, lw, sw, mis, acked;
    r_type = (op == 6'b000000) && rw;
    lw     = (op == 6'b100011);
    sw     = (op == 6'b101011);
    mis    = (lw || sw) && (res % 4 != 0);
    chk("pre.rdy", 32'(in_ready), 1);
    in_valid   = 1'b1;
    opcode     = op;
    alu_rw     = rw;
    dest_reg   = dst;
    alu_result = res;
    store_data = sd;
    mem_ack    = 1'($urandom);
    step();
    mem_ack = 1'b0;
    if (r_type) begin
      junk(1'b1);
      chk("r.rdy", 32'(in_ready), 0);
      chk("r.req", 32'(mem_req), 0);
      chk("r.wbv", 32'(wb_valid), 32'(dst != 0));
      if (dst != 0) begin
        chk("r.wbr", 32'(wb_reg), 32'(dst));
        chk("r.wbd", wb_data, res);
      end
      step();
      junk(1'b0);
      chk_idle("r.post");
    end else if ((lw || sw) && !mis) begin
      acked = 0;
      for (int c = 1; c <= TO; c++) begin
        junk(1'b1);
        chk("m.req", 32'(mem_req), 1);
        chk("m.rdy", 32'(in_ready), 0);
        chk("m.we",  32'(mem_we), 32'(sw));
        chk("m.adr", mem_addr, res);
        if (sw) chk("m.wd", mem_wdata, sd);
        chk("m.wbv", 32'(wb_valid), 0);
        if (c == ack_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
          acked     = 1;
        end else begin
          mem_rdata = $urandom;
        end
        step();
        mem_ack = 1'b0;
        if (acked) break;
      end
      if (acked && lw) begin
        junk(1'b1);
        chk("ld.req", 32'(mem_req), 0);
        chk("ld.rdy", 32'(in_ready), 0);
        chk("ld.wbv", 32'(wb_valid), 32'(dst != 0));
        if (dst != 0) begin
          chk("ld.wbr", 32'(wb_reg), 32'(dst));
          chk("ld.wbd", wb_data, rd);
        end
        chk("ld.to", 32'(err_timeout), 0);
        step();
        junk(1'b0);
        chk_idle("ld.post");
      end else if (acked) begin
        junk(1'b0);
        chk_idle("st.post");
        chk("st.to", 32'(err_timeout), 0);
      end else begin
        junk(1'b0);
        chk_idle("to.post");
        chk("to.pulse", 32'(err_timeout), 1);
        step();
        chk("to.end", 32'(err_timeout), 0);
        chk_idle("to.idle");
      end
    end else begin
      junk(1'b0);
      chk_idle("nop");
      chk("nop.mis", 32'(err_misalign), 32'(mis));
      chk("nop.to",  32'(err_timeout), 0);
      if (mis) begin
        step();
        chk("mis.end", 32'(err_misalign), 0);
      end
    end
  endtask

  initial begin
    logic [5:0]  ops [6];
    logic [5:0]  op;
    logic [31:0] a;
    ops = '{6'b000000, 6'b100011, 6'b101011,
            6'b000100, 6'b000000, 6'b001000};
    rst_n = 1'b0;
    junk(1'b0);
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    #12;
    chk_reset_outs("rst");
    rst_n = 1'b1;

    run_op(6'b000000, 1, 5'd5, 32'h0000_00AB, 0, 0, 0);
    run_op(6'b100011, 0, 5'd8, 32'h100, 0, 3, 32'hDEAD_BEEF);
    run_op(6'b101011, 0, 5'd3, 32'h204, 32'h1234_5678, 1, 0);
    run_op(6'b100011, 0, 5'd8, 32'h102, 0, 1, 0);
    run_op(6'b000100, 0, 5'd9, 32'h40, 0, 1, 0);
    run_op(6'b000000, 0, 5'd9, 32'h40, 0, 1, 0);
    run_op(6'b100011, 0, 5'd7, 32'h300, 0, TO + 1, 0);
    run_op(6'b100011, 0, 5'd7, 32'h300, 0, TO, 32'hCAFE_F00D);
    run_op(6'b101011, 0, 5'd7, 32'h308, 32'h55AA, TO + 1, 0);
    run_op(6'b100011, 0, 5'd0, 32'h10, 0, 2, 32'h1111_2222);
    run_op(6'b000000, 1, 5'd0, 32'h77, 0, 0, 0);

    for (int i = 0; i < 250; i++) begin
      op = ops[$urandom_range(0, 5)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_op(op, (i % 6 != 4) ? 1'($urandom) : 1'b0,
             5'($urandom), a, $urandom,
             $urandom_range(1, TO + 2), $urandom);
    end

    // Reset during the second ACCESS cycle of a load.
    in_valid   = 1'b1;
    opcode     = 6'b100011;
    alu_result = 32'h400;
    dest_reg   = 5'd4;
    step();
    junk(1'b0);
    chk("ra.req1", 32'(mem_req), 1);
    step();
    chk("ra.req2", 32'(mem_req), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("ra.rst");
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    for (int c = 0; c < TO + 3; c++) begin
      step();
      mem_ack = 1'b0;
      chk_idle("ra.post");
      chk("ra.to", 32'(err_timeout), 0);
    end
    run_op(6'b000000, 1, 5'd5, 32'h0000_00AB, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
